// File: rtl/reg_dump_uart_if.sv
// Bundle between the datapath register bus and the UART register-dump stage.
// The master side owns the register bus and triggers; the slave side drives the serial line.
interface reg_dump_uart_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned NREGS  = 6
);
  logic [DWIDTH*NREGS-1:0] rf_out;
  logic                    halt;
  logic                    dump_req;
  logic                    tx;
  logic                    busy;
  logic                    done;

  modport master (
    output rf_out, halt, dump_req,
    input  tx, busy, done
  );

  modport slave (
    input  rf_out, halt, dump_req,
    output tx, busy, done
  );
endinterface

// File: rtl/reg_dump_uart.sv
// Snapshots the packed register file on a halt edge or manual request and streams
// it as "Rn:HHHH\r\n" ASCII lines over an 8N1 UART transmitter.
module reg_dump_uart #(
  parameter int unsigned DWIDTH       = 16,
  parameter int unsigned NREGS        = 6,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input logic            clk,
  input logic            rst,
  reg_dump_uart_if.slave bus
);
  localparam int unsigned CharsPerLine = 5 + DWIDTH / 4;
  localparam int unsigned CharW        = $clog2(CharsPerLine);
  localparam int unsigned RegW         = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned BaudW        = $clog2(CLKS_PER_BIT);

  localparam logic [CharW-1:0] LastChar = CharW'(CharsPerLine - 1);
  localparam logic [CharW-1:0] CrChar   = CharW'(CharsPerLine - 2);
  localparam logic [RegW-1:0]  LastReg  = RegW'(NREGS - 1);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                  state_q, state_d;
  logic [BaudW-1:0]        baud_q, baud_d;
  logic [2:0]              bit_q, bit_d;
  logic [CharW-1:0]        char_q, char_d;
  logic [RegW-1:0]         reg_q, reg_d;
  logic [DWIDTH*NREGS-1:0] snap_q, snap_d;
  logic                    halt_d_q;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;

  logic                    trigger;
  logic                    bit_end;
  logic [DWIDTH-1:0]       cur_reg;
  logic [3:0]              nib;
  logic [7:0]              cur_char;

  assign trigger = (bus.halt & ~halt_d_q) | bus.dump_req;
  assign bit_end = (baud_q == BaudLast);

  // Character under transmission, derived purely from the snapshot and indices.
  always_comb begin
    cur_reg = snap_q[reg_q*DWIDTH +: DWIDTH];
    nib     = 4'(cur_reg >> (DWIDTH - 4 - 4 * (32'(char_q) - 3)));
    if (char_q == '0) begin
      cur_char = 8'h52;
    end else if (char_q == CharW'(1)) begin
      cur_char = 8'h30 + 8'(reg_q);
    end else if (char_q == CharW'(2)) begin
      cur_char = 8'h3A;
    end else if (char_q == CrChar) begin
      cur_char = 8'h0D;
    end else if (char_q == LastChar) begin
      cur_char = 8'h0A;
    end else if (nib < 4'd10) begin
      cur_char = 8'h30 + {4'h0, nib};
    end else begin
      cur_char = 8'h37 + {4'h0, nib};
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    char_d  = char_q;
    reg_d   = reg_q;
    snap_d  = snap_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    // tx_d anticipates the next bit so the line changes exactly on bit boundaries.
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StStart;
          snap_d  = bus.rf_out;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          char_d  = '0;
          reg_d   = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = cur_char[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_char[bit_q + 3'd1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (char_q == LastChar) begin
            char_d = '0;
            if (reg_q == LastReg) begin
              state_d = StIdle;
              reg_d   = '0;
              done_d  = 1'b1;
            end else begin
              reg_d   = reg_q + 1'b1;
              state_d = StStart;
              tx_d    = 1'b0;
            end
          end else begin
            char_d  = char_q + 1'b1;
            state_d = StStart;
            tx_d    = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      char_q   <= '0;
      reg_q    <= '0;
      snap_q   <= '0;
      halt_d_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      char_q   <= char_d;
      reg_q    <= reg_d;
      snap_q   <= snap_d;
      halt_d_q <= bus.halt;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
endmodule

// File: tb/tb_reg_dump_uart.sv
// Randomised bench for reg_dump_uart: a trigger-level model queues expected ASCII bytes,
// and a UART receiver at the falling clock edge decodes tx and scores it against the queue.
module tb_reg_dump_uart;
  localparam int DW        = 16;
  localparam int NR        = 6;
  localparam int CPB       = 4;
  localparam int CPL       = 5 + DW / 4;
  localparam int DumpCyc   = NR * CPL * 10 * CPB;
  localparam int DumpBytes = NR * CPL;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_dump_uart_if #(.DWIDTH(DW), .NREGS(NR)) bus ();

  reg_dump_uart #(
    .DWIDTH      (DW),
    .NREGS       (NR),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a dump is a fixed-length busy window plus a byte list.
  byte unsigned exp_q[$];
  int           m_left   = 0;
  bit           m_done   = 1'b0;
  bit           m_start  = 1'b0;
  bit           m_halt_p = 1'b0;
  int           rst_cnt  = 0;

  function automatic void push_dump(input logic [DW*NR-1:0] v);
    logic [DW-1:0] r;
    int            nib;
    for (int i = 0; i < NR; i++) begin
      r = v[i*DW +: DW];
      exp_q.push_back(8'h52);
      exp_q.push_back(8'(48 + i));
      exp_q.push_back(8'h3A);
      for (int n = DW / 4 - 1; n >= 0; n--) begin
        nib = int'(r[4*n +: 4]);
        exp_q.push_back(nib < 10 ? 8'(48 + nib) : 8'(65 + nib - 10));
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  always @(posedge clk) begin
    m_start = 1'b0;
    m_done  = 1'b0;
    if (rst) begin
      m_left   = 0;
      m_halt_p = 1'b0;
      rst_cnt++;
    end else begin
      if (m_left > 0) begin
        m_left--;
        m_done = (m_left == 0);
      end else if ((bus.halt && !m_halt_p) || bus.dump_req) begin
        m_left  = DumpCyc;
        m_start = 1'b1;
        push_dump(bus.rf_out);
      end
      m_halt_p = bus.halt;
    end
  end

  // Monitor / UART receiver, sampling mid-cycle.
  int         rd          = 0;
  int         seen_rst    = 0;
  int         dec_cnt     = -1;
  logic [7:0] dec_byte    = '0;
  int         rx_count    = 0;
  int         done_count  = 0;
  int         busy_cycles = 0;

  always @(negedge clk) begin
    if (rst_cnt > 0) begin
      check("busy", bus.busy, m_left > 0);
      check("done", bus.done, m_done);
      if (bus.busy) busy_cycles++;
      if (bus.done) done_count++;
      if (m_start) check("tx_low_after_trigger", bus.tx, 1'b0);
      else if (m_left == 0) check("tx_idle_high", bus.tx, 1'b1);

      if (seen_rst != rst_cnt) begin
        seen_rst = rst_cnt;
        dec_cnt  = -1;
        rd       = exp_q.size();
      end

      if (dec_cnt < 0) begin
        if (bus.tx == 1'b0) dec_cnt = 0;
      end else begin
        dec_cnt++;
        if (dec_cnt % CPB == CPB / 2) begin
          if (dec_cnt / CPB == 0) begin
            check("start_bit", bus.tx, 1'b0);
          end else if (dec_cnt / CPB <= 8) begin
            dec_byte[dec_cnt/CPB-1] = bus.tx;
          end else begin
            check("stop_bit", bus.tx, 1'b1);
            check("byte_expected", exp_q.size() > rd, 1'b1);
            if (exp_q.size() > rd) begin
              check("rx_byte", dec_byte, exp_q[rd]);
              rd++;
            end
            rx_count++;
            dec_cnt = -1;
          end
        end
      end
    end
  end

  function automatic logic [DW*NR-1:0] rand_rf();
    logic [DW*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = DW'($urandom());
    return v;
  endfunction

  task automatic pulse_req();
    bus.dump_req = 1'b1;
    @(posedge clk);
    #1 bus.dump_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(posedge clk);
    #1;
    while (m_left > 0 && n < DumpCyc + 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (m_left > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  int base_rx, base_done, base_busy, n;

  initial begin
    bus.rf_out   = '0;
    bus.halt     = 1'b0;
    bus.dump_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Basic dump with fixed register contents
    base_rx = rx_count; base_done = done_count; base_busy = busy_cycles;
    bus.rf_out = {16'h8001, 16'h00F0, 16'hFFFF, 16'h0000, 16'hABCD, 16'h1234};
    pulse_req();
    wait_idle("basic");
    check("basic_bytes", rx_count - base_rx, DumpBytes);
    check("basic_busy_cycles", busy_cycles - base_busy, 2160);
    check("basic_done_pulses", done_count - base_done, 1);

    // Halt trigger held high, then re-armed
    base_rx = rx_count; base_done = done_count;
    bus.rf_out = rand_rf();
    bus.halt   = 1'b1;
    wait_idle("halt");
    repeat (100) @(posedge clk);
    #1;
    check("halt_single_dump", done_count - base_done, 1);
    bus.halt = 1'b0;
    @(posedge clk);
    #1 bus.halt = 1'b1;
    bus.rf_out = rand_rf();
    wait_idle("halt_rearm");
    check("halt_rearm_dumps", done_count - base_done, 2);
    check("halt_rearm_bytes", rx_count - base_rx, 2 * DumpBytes);

    // Snapshot stability under a changing bus
    base_rx = rx_count;
    bus.rf_out = rand_rf();
    pulse_req();
    n = 0;
    while (m_left > 0 && n < DumpCyc + 100) begin
      bus.rf_out = rand_rf();
      @(posedge clk);
      #1;
      n++;
    end
    wait_idle("snapshot");
    check("snapshot_bytes", rx_count - base_rx, DumpBytes);

    // Busy rejection and back-to-back trigger in the done cycle
    base_rx = rx_count; base_done = done_count;
    bus.rf_out = rand_rf();
    pulse_req();
    repeat (300) @(posedge clk);
    #1;
    pulse_req();
    bus.halt = 1'b0;
    repeat (40) @(posedge clk);
    #1 bus.halt = 1'b1;
    n = 0;
    while (!m_done && n < DumpCyc + 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.rf_out = rand_rf();
    pulse_req();
    wait_idle("back_to_back");
    check("reject_done_pulses", done_count - base_done, 2);
    check("reject_bytes", rx_count - base_rx, 2 * DumpBytes);

    // Reset during the data bits of character 20
    bus.halt = 1'b0;
    base_rx = rx_count; base_done = done_count;
    bus.rf_out = rand_rf();
    pulse_req();
    repeat (20 * 10 * CPB + 2 * CPB - 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("reset_no_done", done_count - base_done, 0);
    check("reset_partial_bytes", rx_count - base_rx, 20);
    base_rx = rx_count; base_done = done_count;
    bus.rf_out = rand_rf();
    pulse_req();
    wait_idle("after_reset");
    check("after_reset_bytes", rx_count - base_rx, DumpBytes);
    check("after_reset_done", done_count - base_done, 1);

    // Halt edge and dump_req in the same cycle
    base_rx = rx_count; base_done = done_count;
    bus.rf_out   = rand_rf();
    bus.halt     = 1'b1;
    bus.dump_req = 1'b1;
    @(posedge clk);
    #1 bus.dump_req = 1'b0;
    wait_idle("simultaneous");
    repeat (50) @(posedge clk);
    #1;
    check("simul_bytes", rx_count - base_rx, DumpBytes);
    check("simul_done", done_count - base_done, 1);
    check("pending_bytes", exp_q.size() - rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_dump_uart.md
# reg_dump_uart

Serial register-dump stage that sits directly downstream of the datapath in the unified terminal interface. It consumes the packed register-file bus and the halt flag from the datapath. On a trigger it snapshots all registers and transmits them as ASCII hex lines over an 8N1 UART TX line. This gives the board a terminal view of processor state alongside, or instead of, the VGA display.

## Interface
- DWIDTH, 16: width of one register; must be a multiple of 4
- NREGS, 6: number of registers on the packed bus; maximum 10
- CLKS_PER_BIT, 868: clocks per UART bit (115200 baud at 100 MHz); minimum 2
- clk  input  1  system clock, same clock domain as the datapath
- rst  input  1  reset; one clock, synchronous, active-high
- rf_out  input  DWIDTH*NREGS  packed registers; register i is rf_out[i*DWIDTH +: DWIDTH]
- halt  input  1  datapath halt level; a rising edge triggers a dump
- dump_req  input  1  single-cycle manual dump request
- tx  output  1  UART serial out; idle high
- busy  output  1  high while a dump is in progress
- done  output  1  single-cycle pulse when a dump completes

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **Trigger.** A trigger is either of the following, sampled in IDLE:
  - halt high while the internal halt_d register is low (halt_d resets to 0 and tracks halt every cycle);
  - dump_req high.
- Halt edge and dump_req in the same cycle produce exactly one dump.
- Triggers arriving while busy are ignored, not queued. A halt edge during a dump still updates halt_d, so it does not fire later.
- **Snapshot.** All NREGS*DWIDTH bits are captured on the triggering edge. The transmitted values never change mid-dump, even if rf_out does.
- **Line format.** Each register i, in order 0..NREGS-1, produces one line:
  - 'R' (0x52), then '0'+i, then ':' (0x3A);
  - then DWIDTH/4 hex digits, MSB nibble first;
  - then CR (0x0D) and LF (0x0A).
- **Hex digits.** Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46 (uppercase).
- **Character count.** Characters per line = 5 + DWIDTH/4. Defaults give 9 per line and 54 total.
- **Character selection.** The current character is combinational from the snapshot, the register index and the character index. There are no idle gaps between characters.
- **Frame.** Each character is sent 8N1:
  - START: tx=0;
  - DATA: 8 bits, LSB first;
  - STOP: tx=1.
  - Every bit lasts exactly CLKS_PER_BIT cycles, counted by a baud counter that restarts at each bit boundary.
- **Sequencing.**
  - After STOP, if characters remain, the FSM advances the character index and goes to START.
  - After the LF of the last register, the FSM asserts done and returns to IDLE.
- **Counter widths.** The baud counter is $clog2(CLKS_PER_BIT) bits. The character index is sized for 5 + DWIDTH/4.

## Timing
- **Reset values:** tx=1, busy=0, done=0, FSM=IDLE, halt_d=0, all counters=0.
- **Reset mid-dump:** on the next edge tx=1 and busy=0, and the dump is abandoned. No done pulse is issued and no resume occurs.
- **Trigger latency:** on the edge that samples a trigger, the FSM enters START, busy=1 and tx=0 (tx is registered). tx is low in the first cycle after that edge.
- **Dump duration:** NREGS*(5+DWIDTH/4)*10*CLKS_PER_BIT cycles from the trigger edge until busy falls.
- **End of dump:** on the edge ending the final stop bit, busy goes to 0 and done goes to 1 for exactly one cycle.
  - A trigger sampled in that done cycle is accepted, since the FSM is then in IDLE.
  - The next dump's start bit begins on that sampling edge.
- tx is glitch-free: it is driven only from registers.

## Test plan
- **Basic dump.** CLKS_PER_BIT=4, rf_out = {0x8001, 0x00F0, 0xFFFF, 0x0000, 0xABCD, 0x1234} (reg5..reg0); pulse dump_req.
  - UART decoder receives "R0:1234\r\n" = 52 30 3A 31 32 33 34 0D 0A, through "R5:8001\r\n".
  - 54 bytes total; busy high for exactly 2160 cycles; one done pulse.
- **Halt trigger.** Raise halt and hold it high.
  - Exactly one dump starts; tx is low in the cycle after the sampling edge.
  - No second dump occurs while halt stays high.
  - Drop and re-raise halt after done: a second dump occurs.
- **Snapshot stability.** Change rf_out every cycle during a dump; all bytes match the values present at the trigger edge.
- **Busy rejection.**
  - Pulse dump_req and toggle halt mid-dump: no extra bytes, one done pulse.
  - Pulse dump_req in the done cycle: the next dump starts immediately with no idle bit time.
- **Reset mid-dump.** Assert rst during the DATA state of character 20.
  - Next cycle: tx=1, busy=0, done=0.
  - No further edges on tx until a new trigger; a subsequent dump_req produces a full, correct 54-byte dump.
- **Simultaneous trigger.** halt rising edge and dump_req high in the same cycle: exactly one 54-byte dump.
